// File: rtl/booth_mul_seq_if.sv
// Start/busy/done handshake and operand/result bus between the control unit
// and the sequential Booth multiplier. C[2*WIDTH-1:WIDTH] is HI, C[WIDTH-1:0] is LO.
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] C;

  // Control unit side: issues operands and start, watches busy/done/C.
  modport master (
    output start, A, B,
    input  busy, done, C
  );

  // Multiplier side.
  modport slave (
    input  start, A, B,
    output busy, done, C
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed multiplier, radix-4 Booth recoding, two multiplier bits
// per clock. WIDTH/2 iterations per product; zero-bubble restart from DONE.
//
// state | meaning
// IDLE  | no operation, waiting for start
// RUN   | one Booth iteration per clock, counter tracks iterations done
// DONE  | product in C, done pulse high; start here restarts immediately
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            clear,
  booth_mul_seq_if.slave  bus
);

  // Accumulator layout: {upper (WIDTH+2, incl. 2 guard bits), lower WIDTH, q[-1]}
  localparam int UW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 3;
  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [UW-1:0]      m_q;
  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      acc_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] c_q;

  logic [UW-1:0]      upper;
  logic [UW-1:0]      m2;
  logic [UW-1:0]      addend;
  logic [UW-1:0]      sum;
  logic [AW-1:0]      pre_shift;
  logic               last_iter;

  assign m2        = {m_q[UW-2:0], 1'b0};
  assign last_iter = (cnt_q == CW'(HALF - 1));

  // One Booth step: recode the low triplet, add into the upper part
  // (wrapping mod 2^(WIDTH+2)), then arithmetic shift right by two.
  always_comb begin
    upper  = acc_q[AW-1 -: UW];
    addend = '0;
    case (acc_q[2:0])
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m2;
      3'b100:         addend = -m2;
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
    sum       = upper + addend;
    pre_shift = {sum, acc_q[WIDTH:0]};
    acc_d     = $signed(pre_shift) >>> 2;
  end

  // Control FSM with registered busy/done/C; C is only written on completion.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            m_q     <= {{2{bus.A[WIDTH-1]}}, bus.A};
            acc_q   <= {{UW{1'b0}}, bus.B, 1'b0};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            // Guard bits and q[-1] are dropped; what remains is the exact product.
            c_q     <= acc_d[2*WIDTH:1];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.C    = c_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomized checks of booth_mul_seq (WIDTH=32).
module tb_booth_mul_seq;

  logic clk;
  logic clear;
  int   n_checks;
  int   n_errors;

  booth_mul_seq_if #(.WIDTH(32)) bus ();

  booth_mul_seq #(.WIDTH(32)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one op from the negedge; returns product and edges from accept to done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] c, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    c = bus.C;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] c;
    logic [63:0] ref_p;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    bit          ok;

    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    vecs[4] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[8] = '{32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[9] = '{32'd123456789, 32'd1000,      64'h0000_001C_BE99_1A08};

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_C", bus.C, 64'd0);
    @(negedge clk);
    clear = 1'b1;

    // Table of directed products, each must take exactly 16 edges.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, c, lat);
      check($sformatf("vec%0d_C", i), c, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
    end

    // Start pulses while busy are ignored; busy stays high throughout.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 32'd5;
    bus.B = 32'd6;
    @(posedge clk);
    #1;
    ok = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      bus.start = (i == 5);
      if (i == 5) begin
        bus.A = 32'd100;
        bus.B = 32'd100;
      end
      @(posedge clk);
      #1;
      if (i < 16 && (bus.busy !== 1'b1 || bus.done !== 1'b0)) ok = 1'b0;
    end
    bus.start = 1'b0;
    check("ignore_busy_held", {63'd0, ok}, 64'd1);
    check("ignore_done", {63'd0, bus.done}, 64'd1);
    check("ignore_busy_low_at_done", {63'd0, bus.busy}, 64'd0);
    check("ignore_C", bus.C, 64'd30);
    @(posedge clk);
    #1;
    check("ignore_done_single", {63'd0, bus.done}, 64'd0);

    // Back-to-back: start held in the DONE cycle restarts with no bubble.
    do_op(32'd5, 32'd6, c, lat);
    check("b2b_first_C", c, 64'd30);
    check("b2b_first_lat", 64'(lat), 64'd16);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 32'hFFFF_FFFF;
    bus.B = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_restart_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_restart_done", {63'd0, bus.done}, 64'd0);
    check("b2b_C_held", bus.C, 64'd30);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_second_lat", 64'(lat), 64'd16);
    check("b2b_second_C", bus.C, 64'd1);

    // Asynchronous reset mid-operation abandons the op.
    do_op(32'h7FFF_FFFF, 32'h0000_0003, c, lat);
    check("pre_reset_C", c, 64'h0000_0001_7FFF_FFFD);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 32'd9;
    bus.B = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    clear = 1'b0;
    #1;
    check("midreset_busy", {63'd0, bus.busy}, 64'd0);
    check("midreset_done", {63'd0, bus.done}, 64'd0);
    check("midreset_C", bus.C, 64'd0);
    @(negedge clk);
    clear = 1'b1;
    ok = 1'b1;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("post_reset_quiet", {63'd0, ok}, 64'd1);
    do_op(32'd2, 32'd3, c, lat);
    check("post_reset_C", c, 64'd6);
    check("post_reset_lat", 64'(lat), 64'd16);

    // Random signed pairs against a 64-bit reference product.
    for (int i = 0; i < 1500; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      ref_p = 64'($signed(64'($signed(ra))) * $signed(64'($signed(rb))));
      do_op(ra, rb, c, lat);
      if (c !== ref_p) begin
        n_errors++;
        $display("FAIL rand_C a=%h b=%h: got=%h expected=%h", ra, rb, c, ref_p);
      end
      if (lat != 16) begin
        n_errors++;
        $display("FAIL rand_lat a=%h b=%h: got=%0d expected=16", ra, rb, lat);
      end
      n_checks += 2;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
